// File: rtl/mod_div_unit.sv
// Sequential unsigned divider: remainder (and quotient) by repeated subtraction.
// Define MOD_DIV_QUOTIENT_EN to build the quotient counter; otherwise quotient is 0.
module mod_div_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] quotient
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      COMP = 3'd2,
      SUB  = 3'd3,
      ASGN = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] temp_q, temp_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
`ifdef MOD_DIV_QUOTIENT_EN
   logic [WIDTH-1:0] qcnt_q, qcnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         temp_q  <= '0;
         diff_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef MOD_DIV_QUOTIENT_EN
         qcnt_q  <= '0;
         quo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         temp_q  <= temp_d;
         diff_q  <= diff_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef MOD_DIV_QUOTIENT_EN
         qcnt_q  <= qcnt_d;
         quo_q   <= quo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      temp_d  = temp_q;
      diff_d  = diff_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef MOD_DIV_QUOTIENT_EN
      qcnt_d  = qcnt_q;
      quo_d   = quo_q;
`endif
      case (state_q)
         // DONE accepts a new request directly, skipping IDLE
         IDLE, DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               state_d = LOAD;
            end
         end
         LOAD: begin
            temp_d  = dvd_q;
`ifdef MOD_DIV_QUOTIENT_EN
            qcnt_d  = '0;
`endif
            state_d = COMP;
         end
         COMP: begin
            if (dvs_q == '0) begin
               dbz_d   = 1'b1;
               rem_d   = dvd_q;
`ifdef MOD_DIV_QUOTIENT_EN
               quo_d   = '1;
`endif
               state_d = DONE;
            end else if (temp_q < dvs_q) begin
               dbz_d   = 1'b0;
               rem_d   = temp_q;
`ifdef MOD_DIV_QUOTIENT_EN
               quo_d   = qcnt_q;
`endif
               state_d = DONE;
            end else begin
               state_d = SUB;
            end
         end
         SUB: begin
            diff_d  = temp_q - dvs_q;
            state_d = ASGN;
         end
         ASGN: begin
            temp_d  = diff_q;
`ifdef MOD_DIV_QUOTIENT_EN
            qcnt_d  = qcnt_q + WIDTH'(1);
`endif
            state_d = COMP;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == LOAD) || (state_q == COMP) ||
                        (state_q == SUB)  || (state_q == ASGN);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;
   assign remainder   = rem_q;
`ifdef MOD_DIV_QUOTIENT_EN
   assign quotient    = quo_q;
`else
   assign quotient    = '0;
`endif

endmodule

// File: tb/tb_mod_div_unit.sv
// Directed self-checking bench for mod_div_unit (WIDTH=8); quotient expectations
// follow whether MOD_DIV_QUOTIENT_EN is defined for the build.
module tb_mod_div_unit;

`ifdef MOD_DIV_QUOTIENT_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic       div_by_zero;
   logic [7:0] remainder;
   logic [7:0] quotient;

   int tests = 0;
   int fails = 0;

   mod_div_unit #(.WIDTH(8)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .remainder   (remainder),
      .quotient    (quotient)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qexp(input logic [7:0] q);
      return QEN ? q : 8'd0;
   endfunction

   // Called #1 after a rising edge with the DUT in IDLE or DONE.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_cyc,
                         input logic [7:0] er, input logic [7:0] eq, input logic ez,
                         input logic [7:0] pr, input logic [7:0] pq, input logic pz,
                         input int pulse_at);
      int   cyc;
      bit   seen;
      bit   busy_ok;
      bit   hold_ok;
      string t;
      t = $sformatf("%0d/%0d", a, b);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge CLK); #1;
      start = 1'b0; dividend = 8'hA5; divisor = 8'h5A;
      cyc = 1; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
      while (!seen && cyc < 1000) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (remainder !== pr || quotient !== qexp(pq) || div_by_zero !== pz) hold_ok = 1'b0;
            if (cyc == pulse_at) begin
               start = 1'b1; dividend = 8'd99; divisor = 8'd2;
            end else begin
               start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
         end
      end
      start = 1'b0;
      check({t, " done seen"}, 32'(seen), 32'd1);
      check({t, " done cycle"}, 32'(cyc), 32'(exp_cyc));
      check({t, " busy while running"}, 32'(busy_ok), 32'd1);
      check({t, " prior results held"}, 32'(hold_ok), 32'd1);
      check({t, " busy low at done"}, 32'(busy), 32'd0);
      check({t, " remainder"}, 32'(remainder), 32'(er));
      check({t, " quotient"}, 32'(quotient), 32'(qexp(eq)));
      check({t, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #2;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(posedge CLK); #1;
      reset = 1'b0;
      check("reset remainder", 32'(remainder), 32'd0);
      check("reset quotient", 32'(quotient), 32'd0);
      check("reset div_by_zero", 32'(div_by_zero), 32'd0);

      run_op(8'd17, 8'd5, 12, 8'd2, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0, 0);
      // restart straight from DONE; a start pulse mid-operation must be ignored
      run_op(8'd9, 8'd3, 12, 8'd0, 8'd3, 1'b0, 8'd2, 8'd3, 1'b0, 4);
      run_op(8'd3, 8'd7, 3, 8'd3, 8'd0, 1'b0, 8'd0, 8'd3, 1'b0, 0);
      run_op(8'd200, 8'd0, 3, 8'd200, 8'd255, 1'b1, 8'd3, 8'd0, 1'b0, 0);
      run_op(8'd255, 8'd255, 6, 8'd0, 8'd1, 1'b0, 8'd200, 8'd255, 1'b1, 0);
      run_op(8'd0, 8'd1, 3, 8'd0, 8'd0, 1'b0, 8'd0, 8'd1, 1'b0, 0);

      // reset during SUB of 255/1
      start = 1'b1; dividend = 8'd255; divisor = 8'd1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("255/1 busy in SUB", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset done", 32'(done), 32'd0);
      check("mid reset remainder", 32'(remainder), 32'd0);
      check("mid reset quotient", 32'(quotient), 32'd0);
      check("mid reset div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge CLK); #1;
      reset = 1'b0;
      @(posedge CLK); #1;
      check("idle after reset busy", 32'(busy), 32'd0);
      check("idle after reset done", 32'(done), 32'd0);

      run_op(8'd10, 8'd4, 9, 8'd2, 8'd2, 1'b0, 8'd0, 8'd0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   always @(negedge CLK) begin
      if (busy === 1'b1 && done === 1'b1) begin
         tests++;
         fails++;
         $display("FAIL busy_and_done: observed busy=1 done=1 required not both high");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
